// File: rtl/bridge_dataslot_reader.sv
// Shadows host-written APF dataslot words into a local RAM and serves per-slot
// queries (id, flags, size, written) to core logic over a valid/ready handshake.
module bridge_dataslot_reader #(
   parameter logic [31:0] BASE_ADDR = 32'hF800_2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] bridge_addr,
   input  logic        bridge_wr,
   input  logic [31:0] bridge_wr_data,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_slot,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [4:0]  resp_slot,
   output logic [15:0] resp_id,
   output logic [15:0] resp_flags,
   output logic [31:0] resp_size,
   output logic        resp_written,
   output logic [31:0] slot_written
);

   typedef enum logic [2:0] {IDLE, RD0, RD1, CAP, RESP} state_t;

   state_t      state;
   state_t      state_next;
   logic        hit;
   logic        bwr;
   logic        bwr_same_slot;
   logic [4:0]  slot_q;
   logic [5:0]  rd_addr;
   logic [31:0] ram_q;
   logic [31:0] word0;
   logic [31:0] mem [64];
   logic        unused_addr_bits;

   assign hit              = (bridge_addr[31:8] == BASE_ADDR[31:8]);
   assign bwr              = bridge_wr && hit;
   assign bwr_same_slot    = bwr && (bridge_addr[7:3] == slot_q);
   assign rd_addr          = {slot_q, (state == RD1)};
   assign unused_addr_bits = ^bridge_addr[1:0];

   // Single-port RAM: a bridge write owns the port, so the read result holds that cycle.
   always_ff @(posedge clk) begin
      if (bwr) begin
         mem[bridge_addr[7:2]] <= bridge_wr_data;
      end else begin
         ram_q <= mem[rd_addr];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_written <= '0;
      end else if (bwr && bridge_addr[2]) begin
         slot_written[bridge_addr[7:3]] <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A write to the queried slot restarts the read so a response never mixes old and new words.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (req_valid) state_next = RD0;
         RD0:  if (!bwr) state_next = RD1;
         RD1: begin
            if (bwr_same_slot) begin
               state_next = RD0;
            end else if (!bwr) begin
               state_next = CAP;
            end
         end
         CAP:  state_next = bwr_same_slot ? RD0 : RESP;
         RESP: if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);

   // Fields of never-completed slots are masked so stale pre-reset RAM contents never leak out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_q       <= '0;
         word0        <= '0;
         resp_slot    <= '0;
         resp_id      <= '0;
         resp_flags   <= '0;
         resp_size    <= '0;
         resp_written <= 1'b0;
      end else begin
         if ((state == IDLE) && req_valid) begin
            slot_q <= req_slot;
         end
         if (state == RD1) begin
            word0 <= ram_q;
         end
         if ((state == CAP) && !bwr_same_slot) begin
            resp_slot    <= slot_q;
            resp_written <= slot_written[slot_q];
            if (slot_written[slot_q]) begin
               resp_id    <= word0[15:0];
               resp_flags <= word0[31:16];
               resp_size  <= ram_q;
            end else begin
               resp_id    <= '0;
               resp_flags <= '0;
               resp_size  <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_bridge_dataslot_reader.sv
// Directed bench for bridge_dataslot_reader: a bridge-write model predicts each
// query response, queued on issue and compared when the DUT presents it.
module tb_bridge_dataslot_reader;

   localparam logic [31:0] BASE = 32'hF800_2000;

   logic        clk;
   logic        reset;
   logic [31:0] bridge_addr;
   logic        bridge_wr;
   logic [31:0] bridge_wr_data;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_slot;
   logic        resp_valid;
   logic        resp_ready;
   logic [4:0]  resp_slot;
   logic [15:0] resp_id;
   logic [15:0] resp_flags;
   logic [31:0] resp_size;
   logic        resp_written;
   logic [31:0] slot_written;

   typedef struct packed {
      logic [4:0]  slot;
      logic [15:0] id;
      logic [15:0] flags;
      logic [31:0] size;
      logic        written;
   } resp_t;

   resp_t       sb[$];
   logic [31:0] mem_model [64];
   logic [31:0] written_model;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          accept_cyc = 0;

   bridge_dataslot_reader #(.BASE_ADDR(BASE)) dut (
      .clk(clk),
      .reset(reset),
      .bridge_addr(bridge_addr),
      .bridge_wr(bridge_wr),
      .bridge_wr_data(bridge_wr_data),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_slot(req_slot),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_slot(resp_slot),
      .resp_id(resp_id),
      .resp_flags(resp_flags),
      .resp_size(resp_size),
      .resp_written(resp_written),
      .slot_written(slot_written)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
      bridge_addr    = addr;
      bridge_wr_data = data;
      bridge_wr      = 1'b1;
      @(posedge clk);
      #1;
      bridge_wr      = 1'b0;
      if (addr[31:8] == BASE[31:8]) begin
         mem_model[addr[7:2]] = data;
         if (addr[2]) written_model[addr[7:3]] = 1'b1;
      end
   endtask

   function automatic resp_t expectFor(input logic [4:0] s);
      resp_t r;
      r.slot    = s;
      r.written = written_model[s];
      if (written_model[s]) begin
         r.id    = mem_model[{s, 1'b0}][15:0];
         r.flags = mem_model[{s, 1'b0}][31:16];
         r.size  = mem_model[{s, 1'b1}];
      end else begin
         r.id    = '0;
         r.flags = '0;
         r.size  = '0;
      end
      return r;
   endfunction

   task automatic pushExpect(input logic [4:0] s);
      sb.push_back(expectFor(s));
   endtask

   task automatic issueQuery(input logic [4:0] s);
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
      req_slot  = s;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      accept_cyc = cyc;
   endtask

   task automatic awaitResponse(input string tag, input int exp_lat);
      int    n;
      resp_t e;
      n = 0;
      while (!resp_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
      if (!resp_valid) return;
      if (exp_lat >= 0) checkOutput({tag, "_latency"}, cyc - accept_cyc, exp_lat);
      if (sb.size() == 0) begin
         checkOutput({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      checkOutput({tag, "_slot"}, {27'd0, resp_slot}, {27'd0, e.slot});
      checkOutput({tag, "_id"}, {16'd0, resp_id}, {16'd0, e.id});
      checkOutput({tag, "_flags"}, {16'd0, resp_flags}, {16'd0, e.flags});
      checkOutput({tag, "_size"}, resp_size, e.size);
      checkOutput({tag, "_written"}, {31'd0, resp_written}, {31'd0, e.written});
      if (resp_ready) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      resp_t hold_exp;
      reset          = 1'b1;
      bridge_addr    = '0;
      bridge_wr      = 1'b0;
      bridge_wr_data = '0;
      req_valid      = 1'b0;
      req_slot       = '0;
      resp_ready     = 1'b1;
      written_model  = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
      checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("rst_resp_id", {16'd0, resp_id}, 32'd0);
      checkOutput("rst_resp_size", resp_size, 32'd0);
      checkOutput("rst_slot_written", slot_written, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] write slot 3 and query it");
      applyStimulus(BASE + 32'h18, 32'h0001_00AB);
      applyStimulus(BASE + 32'h1C, 32'h0004_0000);
      checkOutput("slot_written_after_s3", slot_written, written_model);
      issueQuery(5'd3);
      pushExpect(5'd3);
      awaitResponse("q3", 3);

      $display("[TB] query never-written slot 7");
      issueQuery(5'd7);
      pushExpect(5'd7);
      awaitResponse("q7", 3);

      $display("[TB] query slot 3 with bridge writes to slot 9 stalling RD0");
      issueQuery(5'd3);
      for (int i = 0; i < 4; i++) applyStimulus(BASE + 32'h48, 32'h9900_0000 + i);
      pushExpect(5'd3);
      awaitResponse("stall", 7);

      $display("[TB] query slot 3 with a size rewrite during RD1");
      issueQuery(5'd3);
      @(posedge clk);
      #1;
      applyStimulus(BASE + 32'h1C, 32'h0000_0010);
      pushExpect(5'd3);
      awaitResponse("restart", 5);

      $display("[TB] hold resp_ready low for 10 cycles");
      resp_ready = 1'b0;
      issueQuery(5'd3);
      pushExpect(5'd3);
      hold_exp = expectFor(5'd3);
      awaitResponse("hold", 3);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checkOutput("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
         checkOutput("hold_req_ready", {31'd0, req_ready}, 32'd0);
         checkOutput("hold_resp_size", resp_size, hold_exp.size);
         checkOutput("hold_resp_id", {16'd0, resp_id}, {16'd0, hold_exp.id});
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("release_req_ready", {31'd0, req_ready}, 32'd1);
      checkOutput("release_resp_valid", {31'd0, resp_valid}, 32'd0);
      issueQuery(5'd7);
      pushExpect(5'd7);
      awaitResponse("after_hold", 3);

      $display("[TB] write outside the window");
      applyStimulus(BASE + 32'h100, 32'hDEAD_BEEF);
      checkOutput("outside_slot_written", slot_written, written_model);
      issueQuery(5'd3);
      pushExpect(5'd3);
      awaitResponse("after_outside", 3);

      $display("[TB] reset during RD1");
      issueQuery(5'd3);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      written_model = '0;
      sb.delete();
      checkOutput("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("midrst_slot_written", slot_written, 32'd0);
      checkOutput("midrst_req_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("postrst_no_resp", {31'd0, resp_valid}, 32'd0);
      end
      issueQuery(5'd3);
      pushExpect(5'd3);
      awaitResponse("requery", 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
